// File: rtl/uart_rxfsm_if.sv
// Signal bundle between the UART receive FSM and its surroundings:
// configuration, the serial line, and the RX FIFO write side.
interface uart_rxfsm_if;
    logic       cfg_rx_enable;
    logic       cfg_stop_bit;
    logic [1:0] cfg_pri_mod;
    logic       si;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_data;
    logic       par_error;
    logic       frm_error;
    logic       rx_overrun;

    modport master (
        output cfg_rx_enable, cfg_stop_bit, cfg_pri_mod, si, fifo_full,
        input  fifo_wr, fifo_data, par_error, frm_error, rx_overrun
    );

    modport slave (
        input  cfg_rx_enable, cfg_stop_bit, cfg_pri_mod, si, fifo_full,
        output fifo_wr, fifo_data, par_error, frm_error, rx_overrun
    );
endinterface

// File: rtl/uart_rxfsm.sv
// UART receive FSM on the 16x baud clock: qualifies the start bit mid-bit,
// recovers 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_rxfsm (
    input  logic         baud_clk_16x,
    input  logic         reset_n,
    uart_rxfsm_if.slave  rx
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP1 = 3'd4;
    localparam logic [2:0] STOP2 = 3'd5;

    logic       sync1_q, si_s_q;
    logic [2:0] rxstate_q, rxstate_d;
    logic [3:0] divcnt_q, divcnt_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rxdata_q, rxdata_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       fifo_wr_q, fifo_wr_d;
    logic [7:0] fifo_data_q, fifo_data_d;
    logic       par_error_q, par_error_d;
    logic       frm_error_q, frm_error_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       bit_mid;
    logic       par_exp;
    logic       complete;

    assign bit_mid = (divcnt_q == 4'd15);
    assign par_exp = rx.cfg_pri_mod[0] ? ~^rxdata_q : ^rxdata_q;

    always_comb begin
        rxstate_d    = rxstate_q;
        divcnt_d     = divcnt_q + 4'd1;
        cnt_d        = cnt_q;
        rxdata_d     = rxdata_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;
        par_error_d  = 1'b0;
        frm_error_d  = 1'b0;
        rx_overrun_d = 1'b0;
        complete     = 1'b0;

        if (!rx.cfg_rx_enable) begin
            rxstate_d = IDLE;
            divcnt_d  = 4'd0;
            cnt_d     = 3'd0;
            rxdata_d  = 8'h00;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
        end else begin
            case (rxstate_q)
                IDLE: begin
                    divcnt_d = 4'd0;
                    if (!si_s_q) rxstate_d = START;
                end
                START: begin
                    // A start bit that is high again by mid-bit was a glitch.
                    if (divcnt_q == 4'd7) begin
                        divcnt_d  = 4'd0;
                        cnt_d     = 3'd0;
                        rxstate_d = si_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_mid) begin
                        rxdata_d[cnt_q] = si_s_q;
                        cnt_d           = cnt_q + 3'd1;
                        if (cnt_q == 3'd7)
                            rxstate_d = (rx.cfg_pri_mod != 2'b00) ? PAR : STOP1;
                    end
                end
                PAR: begin
                    if (bit_mid) begin
                        if (si_s_q != par_exp) perr_d = 1'b1;
                        rxstate_d = STOP1;
                    end
                end
                STOP1: begin
                    if (bit_mid) begin
                        if (!si_s_q) ferr_d = 1'b1;
                        if (rx.cfg_stop_bit) rxstate_d = STOP2;
                        else                 complete  = 1'b1;
                    end
                end
                STOP2: begin
                    if (bit_mid) begin
                        if (!si_s_q) ferr_d = 1'b1;
                        complete = 1'b1;
                    end
                end
                default: rxstate_d = IDLE;
            endcase

            // ferr_d already includes the stop sample taken on this edge.
            if (complete) begin
                if (!rx.fifo_full) begin
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = rxdata_q;
                    par_error_d = perr_q;
                    frm_error_d = ferr_d;
                end else begin
                    rx_overrun_d = 1'b1;
                end
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
                divcnt_d  = 4'd0;
                rxstate_d = IDLE;
            end
        end
    end

    always_ff @(posedge baud_clk_16x or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b1;
            si_s_q       <= 1'b1;
            rxstate_q    <= IDLE;
            divcnt_q     <= 4'd0;
            cnt_q        <= 3'd0;
            rxdata_q     <= 8'h00;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= 8'h00;
            par_error_q  <= 1'b0;
            frm_error_q  <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            sync1_q      <= rx.si;
            si_s_q       <= sync1_q;
            rxstate_q    <= rxstate_d;
            divcnt_q     <= divcnt_d;
            cnt_q        <= cnt_d;
            rxdata_q     <= rxdata_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            par_error_q  <= par_error_d;
            frm_error_q  <= frm_error_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx.fifo_wr    = fifo_wr_q;
    assign rx.fifo_data  = fifo_data_q;
    assign rx.par_error  = par_error_q;
    assign rx.frm_error  = frm_error_q;
    assign rx.rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_rxfsm.sv
// Bench for uart_rxfsm: a serial transmitter model drives whole characters and
// predicts each FIFO write (time, data, error flags) from frame-length arithmetic.
module tb_uart_rxfsm;

    typedef struct packed {
        logic [31:0] t;
        logic [7:0]  d;
        logic        pe;
        logic        fe;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   stray      = 0;
    logic [7:0] last_data = 8'h00;

    rec_t obs_q[$];
    rec_t exp_q[$];
    int   ovr_q[$];
    int   exp_ovr_q[$];
    rec_t mon_r;

    uart_rxfsm_if bus();

    uart_rxfsm dut (
        .baud_clk_16x (clk),
        .reset_n      (rst_n),
        .rx           (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.fifo_wr === 1'b1) begin
            mon_r.t  = cyc;
            mon_r.d  = bus.fifo_data;
            mon_r.pe = bus.par_error;
            mon_r.fe = bus.frm_error;
            obs_q.push_back(mon_r);
            $display("rx write  t=%0d data=%02h par_error=%b frm_error=%b",
                     cyc, bus.fifo_data, bus.par_error, bus.frm_error);
        end else if (bus.par_error !== 1'b0 || bus.frm_error !== 1'b0) begin
            stray++;
        end
        if (bus.rx_overrun === 1'b1) begin
            ovr_q.push_back(cyc);
            $display("rx overrun t=%0d", cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.si = b;
        step(16);
    endtask

    // Transmit one character with the current cfg and record what the
    // receiver must report: a write (or an overrun) after the last stop mid-bit.
    task automatic send_frame(input logic [7:0] d, input logic flip_par,
                              input logic stop1, input logic stop2);
        int   t0;
        int   dur;
        logic has_par;
        logic ones_odd;
        logic pbit;
        rec_t e;
        t0       = cyc;
        has_par  = (bus.cfg_pri_mod != 2'b00);
        ones_odd = ($countones(d) % 2) == 1;
        pbit     = ((bus.cfg_pri_mod == 2'b10) ? ones_odd : !ones_odd) ^ flip_par;
        // 2 sync clocks + idle detect, then 9.5 bit times to the first stop mid-bit.
        dur = 3 + 152 + (has_par ? 16 : 0) + (bus.cfg_stop_bit ? 16 : 0);
        if (bus.fifo_full) begin
            exp_ovr_q.push_back(t0 + dur);
        end else begin
            e.t  = t0 + dur;
            e.d  = d;
            e.pe = has_par && flip_par;
            e.fe = !stop1 || (bus.cfg_stop_bit && !stop2);
            exp_q.push_back(e);
            last_data = d;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(stop1);
        if (bus.cfg_stop_bit) drive_bit(stop2);
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic two_stop);
        bus.cfg_rx_enable = 1'b0;
        step(1);
        bus.cfg_pri_mod   = mode;
        bus.cfg_stop_bit  = two_stop;
        bus.cfg_rx_enable = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        step(3);
        compared++;
        if ({bus.fifo_wr, bus.par_error, bus.frm_error, bus.rx_overrun} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_pulses: got wr/pe/fe/ov=%b%b%b%b, want 0000",
                     bus.fifo_wr, bus.par_error, bus.frm_error, bus.rx_overrun);
        end
        compared++;
        if (bus.fifo_data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data: got %02h, want 00", bus.fifo_data);
        end
        rst_n = 1'b1;
        step(50);
        compared++;
        if (obs_q.size() !== 0 || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL reset_idle: got %0d writes %0d overruns, want 0 0", obs_q.size(), ovr_q.size());
        end
        obs_q.delete(); ovr_q.delete();
    endtask

    task automatic test_basic();
        rec_t o, e;
        set_cfg(2'b00, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        step(40);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL basic_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL basic_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_parity();
        rec_t o, e;
        set_cfg(2'b10, 1'b1);
        send_frame(8'h03, 1'b0, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        step(40);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL parity_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL parity_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_break();
        rec_t o, e;
        int   t_first;
        set_cfg(2'b00, 1'b0);
        t_first = cyc + 155;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        // Line stays low: each further 153 clocks (152 + one idle-detect edge)
        // frames another all-zero character with a bad stop bit.
        step(304);
        for (int i = 1; i <= 2; i++) begin
            e.t = t_first + 153 * i; e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1;
            exp_q.push_back(e);
        end
        last_data = 8'h00;
        bus.si = 1'b1;
        step(100);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL break_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL break_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_glitch();
        rec_t o, e;
        bus.si = 1'b0;
        step(4);
        bus.si = 1'b1;
        step(30);
        compared++;
        if (obs_q.size() !== 0 || stray !== 0) begin
            mismatched++;
            $display("FAIL glitch_reject: got %0d writes %0d stray errors, want 0 0", obs_q.size(), stray);
        end
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        step(40);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL glitch_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL glitch_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_overrun();
        int o, e;
        bus.fifo_full = 1'b1;
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        step(40);
        bus.fifo_full = 1'b0;
        compared++;
        if (obs_q.size() !== 0 || ovr_q.size() !== exp_ovr_q.size()) begin
            mismatched++;
            $display("FAIL overrun_count: got %0d writes %0d overruns, want 0 %0d", obs_q.size(), ovr_q.size(), exp_ovr_q.size());
        end
        while (ovr_q.size() > 0 && exp_ovr_q.size() > 0) begin
            o = ovr_q.pop_front(); e = exp_ovr_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL overrun_time: got t=%0d, want t=%0d", o, e);
            end
        end
        compared++;
        if (bus.fifo_data !== last_data || stray !== 0) begin
            mismatched++;
            $display("FAIL overrun_hold: got data=%02h stray=%0d, want data=%02h stray=0", bus.fifo_data, stray, last_data);
        end
        obs_q.delete(); ovr_q.delete(); exp_ovr_q.delete();
    endtask

    task automatic test_enable_drop();
        rec_t o, e;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        bus.cfg_rx_enable = 1'b0;
        step(3);
        bus.cfg_rx_enable = 1'b1;
        step(30);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        step(40);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL enable_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL enable_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_reset_mid();
        rec_t o, e;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #2;
        last_data = 8'h00;
        compared++;
        if ({bus.fifo_wr, bus.fifo_data} !== 9'h000) begin
            mismatched++;
            $display("FAIL async_reset: got wr=%b data=%02h, want wr=0 data=00", bus.fifo_wr, bus.fifo_data);
        end
        step(3);
        rst_n = 1'b1;
        step(30);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        step(40);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL rstmid_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL rstmid_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        set_cfg(2'b11, 1'b1);
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b0, 1'b1, 1'b1);
        step(60);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d writes %0d overruns, want %0d 0", obs_q.size(), ovr_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL b2b_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    task automatic test_random();
        rec_t o, e;
        logic [1:0] mode;
        logic       flip;
        int         gap;
        for (int n = 0; n < 12; n++) begin
            mode = 2'($urandom_range(0, 3));
            set_cfg(mode, 1'($urandom_range(0, 1)));
            flip = (mode != 2'b00) && ($urandom_range(0, 1) == 1);
            send_frame(8'($urandom), flip, 1'b1, 1'b1);
            gap = $urandom_range(0, 3);
            if (gap > 0) step(gap);
        end
        step(60);
        compared++;
        if (obs_q.size() !== exp_q.size() || ovr_q.size() !== 0 || stray !== 0) begin
            mismatched++;
            $display("FAIL random_count: got %0d writes %0d overruns %0d stray, want %0d 0 0",
                     obs_q.size(), ovr_q.size(), stray, exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL random_write: got t=%0d d=%02h pe=%b fe=%b, want t=%0d d=%02h pe=%b fe=%b",
                         o.t, o.d, o.pe, o.fe, e.t, e.d, e.pe, e.fe);
            end
        end
        obs_q.delete(); exp_q.delete(); ovr_q.delete();
    endtask

    initial begin
        bus.si            = 1'b1;
        bus.cfg_rx_enable = 1'b1;
        bus.cfg_stop_bit  = 1'b0;
        bus.cfg_pri_mod   = 2'b00;
        bus.fifo_full     = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
